// File: rtl/rx_frame_deserializer_if.sv
// Bus between the RX data sampler / system side and the frame deserializer.
//   master : sampler side, drives strobes and frame config, receives results
//   slave  : deserializer side
// Signals:
//   start_det, bit_valid, sampled_bit, frame_abort : sampler strobes/data
//   PAR_EN, PAR_TYP                                : frame config
//   P_DATA, data_valid, par_err, stp_err, busy     : frame results/status
interface rx_frame_deserializer_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  start_det;
   logic                  bit_valid;
   logic                  sampled_bit;
   logic                  frame_abort;
   logic                  PAR_EN;
   logic                  PAR_TYP;
   logic [DATA_WIDTH-1:0] P_DATA;
   logic                  data_valid;
   logic                  par_err;
   logic                  stp_err;
   logic                  busy;

   modport master (
      output start_det, bit_valid, sampled_bit, frame_abort, PAR_EN, PAR_TYP,
      input  P_DATA, data_valid, par_err, stp_err, busy
   );

   modport slave (
      input  start_det, bit_valid, sampled_bit, frame_abort, PAR_EN, PAR_TYP,
      output P_DATA, data_valid, par_err, stp_err, busy
   );
endinterface

// File: rtl/rx_frame_deserializer.sv
// UART RX frame deserializer. Collects DATA_WIDTH data bits, an optional
// parity bit and STOP_BITS stop bits from sampler strobes, then publishes
// the payload on P_DATA (error-free frames only) with one-cycle result pulses.
// Ports:
//   CLK : RX oversampling-domain clock
//   RST : asynchronous active-high reset
//   rx  : slave side of rx_frame_deserializer_if (strobes in, results out)
module rx_frame_deserializer #(
   parameter int DATA_WIDTH = 8,
   parameter bit LSB_FIRST  = 1'b1,
   parameter int STOP_BITS  = 1
) (
   input logic                     CLK,
   input logic                     RST,
   rx_frame_deserializer_if.slave  rx
);

   localparam int CW = $clog2(DATA_WIDTH + 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_DATA   = 2'd1;
   localparam logic [1:0] S_PARITY = 2'd2;
   localparam logic [1:0] S_STOP   = 2'd3;

   logic [1:0]            state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  stp_cnt_q, stp_cnt_d;
   logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
   logic                  acc_q, acc_d;
   logic                  pen_q, pen_d;
   logic                  ptyp_q, ptyp_d;
   logic                  perr_q, perr_d;
   logic                  serr_q, serr_d;
   logic [DATA_WIDTH-1:0] pdata_q, pdata_d;
   logic                  dv_q, dv_d;
   logic                  pe_q, pe_d;
   logic                  se_q, se_d;
   logic                  busy_q, busy_d;

   logic [CW-1:0]         idx;
   logic                  serr_now;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      stp_cnt_d = stp_cnt_q;
      shreg_d   = shreg_q;
      acc_d     = acc_q;
      pen_d     = pen_q;
      ptyp_d    = ptyp_q;
      perr_d    = perr_q;
      serr_d    = serr_q;
      pdata_d   = pdata_q;
      dv_d      = 1'b0;
      pe_d      = 1'b0;
      se_d      = 1'b0;
      idx       = LSB_FIRST ? cnt_q : (CW'(DATA_WIDTH - 1) - cnt_q);
      serr_now  = serr_q | ~rx.sampled_bit;

      if (rx.frame_abort) begin
         // Abort outranks everything, including a same-cycle start_det.
         state_d   = S_IDLE;
         cnt_d     = '0;
         stp_cnt_d = 1'b0;
         acc_d     = 1'b0;
         perr_d    = 1'b0;
         serr_d    = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               // A bit_valid arriving with start_det belongs to the start bit.
               if (rx.start_det) begin
                  pen_d     = rx.PAR_EN;
                  ptyp_d    = rx.PAR_TYP;
                  cnt_d     = '0;
                  stp_cnt_d = 1'b0;
                  acc_d     = 1'b0;
                  perr_d    = 1'b0;
                  serr_d    = 1'b0;
                  state_d   = S_DATA;
               end
            end
            S_DATA: begin
               if (rx.bit_valid) begin
                  for (int i = 0; i < DATA_WIDTH; i++)
                     if (idx == CW'(i)) shreg_d[i] = rx.sampled_bit;
                  acc_d = acc_q ^ rx.sampled_bit;
                  cnt_d = cnt_q + 1'b1;
                  // Leave DATA on the same edge the counter hits DATA_WIDTH.
                  if (cnt_d == CW'(DATA_WIDTH))
                     state_d = pen_q ? S_PARITY : S_STOP;
               end
            end
            S_PARITY: begin
               if (rx.bit_valid) begin
                  perr_d  = rx.sampled_bit != (acc_q ^ ptyp_q);
                  state_d = S_STOP;
               end
            end
            S_STOP: begin
               if (rx.bit_valid) begin
                  if (stp_cnt_q == 1'(STOP_BITS - 1)) begin
                     state_d = S_IDLE;
                     serr_d  = serr_now;
                     if (!perr_q && !serr_now) begin
                        pdata_d = shreg_q;
                        dv_d    = 1'b1;
                     end else begin
                        pe_d = perr_q;
                        se_d = serr_now;
                     end
                  end else begin
                     serr_d    = serr_now;
                     stp_cnt_d = 1'b1;
                  end
               end
            end
            default: state_d = S_IDLE;
         endcase
      end

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         stp_cnt_q <= 1'b0;
         shreg_q   <= '0;
         acc_q     <= 1'b0;
         pen_q     <= 1'b0;
         ptyp_q    <= 1'b0;
         perr_q    <= 1'b0;
         serr_q    <= 1'b0;
         pdata_q   <= '0;
         dv_q      <= 1'b0;
         pe_q      <= 1'b0;
         se_q      <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         stp_cnt_q <= stp_cnt_d;
         shreg_q   <= shreg_d;
         acc_q     <= acc_d;
         pen_q     <= pen_d;
         ptyp_q    <= ptyp_d;
         perr_q    <= perr_d;
         serr_q    <= serr_d;
         pdata_q   <= pdata_d;
         dv_q      <= dv_d;
         pe_q      <= pe_d;
         se_q      <= se_d;
         busy_q    <= busy_d;
      end
   end

   assign rx.P_DATA     = pdata_q;
   assign rx.data_valid = dv_q;
   assign rx.par_err    = pe_q;
   assign rx.stp_err    = se_q;
   assign rx.busy       = busy_q;

endmodule

// File: tb/tb_rx_frame_deserializer.sv
// Directed bench for rx_frame_deserializer. Three instances cover
// (8b LSB-first, 1 stop), (8b LSB-first, 2 stops) and (5b MSB-first, 1 stop).
// A frame-level model (bit list per frame, resolved by arithmetic once the
// frame length is reached) predicts outputs, checked every cycle.
module tb_rx_frame_deserializer;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int   sel;
   logic start_det, bit_valid, sampled_bit, frame_abort, par_en, par_typ;
   int   vectors = 0;
   int   miscompares = 0;
   bit   chk_en = 1'b0;

   rx_frame_deserializer_if #(.DATA_WIDTH(8)) if0 ();
   rx_frame_deserializer_if #(.DATA_WIDTH(8)) if1 ();
   rx_frame_deserializer_if #(.DATA_WIDTH(5)) if2 ();

   rx_frame_deserializer #(.DATA_WIDTH(8), .LSB_FIRST(1'b1), .STOP_BITS(1))
      u0 (.CLK(clk), .RST(rst), .rx(if0));
   rx_frame_deserializer #(.DATA_WIDTH(8), .LSB_FIRST(1'b1), .STOP_BITS(2))
      u1 (.CLK(clk), .RST(rst), .rx(if1));
   rx_frame_deserializer #(.DATA_WIDTH(5), .LSB_FIRST(1'b0), .STOP_BITS(1))
      u2 (.CLK(clk), .RST(rst), .rx(if2));

   // Only the selected instance sees strobes; config is shared.
   assign if0.start_det = (sel == 0) && start_det;
   assign if1.start_det = (sel == 1) && start_det;
   assign if2.start_det = (sel == 2) && start_det;
   assign if0.bit_valid = (sel == 0) && bit_valid;
   assign if1.bit_valid = (sel == 1) && bit_valid;
   assign if2.bit_valid = (sel == 2) && bit_valid;
   assign if0.frame_abort = (sel == 0) && frame_abort;
   assign if1.frame_abort = (sel == 1) && frame_abort;
   assign if2.frame_abort = (sel == 2) && frame_abort;
   assign if0.sampled_bit = sampled_bit;
   assign if1.sampled_bit = sampled_bit;
   assign if2.sampled_bit = sampled_bit;
   assign if0.PAR_EN = par_en;
   assign if1.PAR_EN = par_en;
   assign if2.PAR_EN = par_en;
   assign if0.PAR_TYP = par_typ;
   assign if1.PAR_TYP = par_typ;
   assign if2.PAR_TYP = par_typ;

   logic [15:0] o_pdata [3];
   logic        o_dv [3], o_pe [3], o_se [3], o_busy [3];
   assign o_pdata[0] = {8'b0, if0.P_DATA};
   assign o_pdata[1] = {8'b0, if1.P_DATA};
   assign o_pdata[2] = {11'b0, if2.P_DATA};
   assign o_dv[0] = if0.data_valid;  assign o_dv[1] = if1.data_valid;  assign o_dv[2] = if2.data_valid;
   assign o_pe[0] = if0.par_err;     assign o_pe[1] = if1.par_err;     assign o_pe[2] = if2.par_err;
   assign o_se[0] = if0.stp_err;     assign o_se[1] = if1.stp_err;     assign o_se[2] = if2.stp_err;
   assign o_busy[0] = if0.busy;      assign o_busy[1] = if1.busy;      assign o_busy[2] = if2.busy;

   // ---------------- frame-level model ----------------
   function automatic int dw_of(input int s);
      return (s == 2) ? 5 : 8;
   endfunction
   function automatic bit lsb_of(input int s);
      return (s != 2);
   endfunction
   function automatic int sb_of(input int s);
      return (s == 1) ? 2 : 1;
   endfunction

   logic [15:0] m_pdata [3];
   logic        m_dv [3], m_pe [3], m_se [3], m_busy [3], m_pen [3], m_ptyp [3];
   logic [31:0] m_bits [3];
   int          m_n [3];

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         m_pdata[i] = '0; m_dv[i] = 0; m_pe[i] = 0; m_se[i] = 0;
         m_busy[i] = 0; m_pen[i] = 0; m_ptyp[i] = 0; m_bits[i] = '0; m_n[i] = 0;
      end
   endtask

   task automatic model_resolve(input int s);
      int          dw;
      logic [15:0] data;
      logic        perr, serr;
      dw   = dw_of(s);
      data = '0;
      for (int k = 0; k < dw; k++)
         if (m_bits[s][k]) data = data | (16'd1 << (lsb_of(s) ? k : dw - 1 - k));
      perr = m_pen[s] && (m_bits[s][dw] != ((^data) ^ m_ptyp[s]));
      serr = 1'b0;
      for (int j = 0; j < sb_of(s); j++)
         if (!m_bits[s][dw + int'(m_pen[s]) + j]) serr = 1'b1;
      if (!perr && !serr) begin
         m_pdata[s] = data;
         m_dv[s]    = 1'b1;
      end else begin
         m_pe[s] = perr;
         m_se[s] = serr;
      end
      m_busy[s] = 1'b0;
   endtask

   task automatic model_step(input int s, input bit st, input bit bv, input bit b, input bit ab);
      for (int i = 0; i < 3; i++) begin
         m_dv[i] = 0; m_pe[i] = 0; m_se[i] = 0;
      end
      if (ab) begin
         m_busy[s] = 1'b0;
         m_n[s]    = 0;
      end else if (!m_busy[s]) begin
         if (st) begin
            m_busy[s] = 1'b1;
            m_pen[s]  = par_en;
            m_ptyp[s] = par_typ;
            m_n[s]    = 0;
            m_bits[s] = '0;
         end
      end else if (bv) begin
         m_bits[s][m_n[s]] = b;
         m_n[s] = m_n[s] + 1;
         if (m_n[s] == dw_of(s) + int'(m_pen[s]) + sb_of(s)) model_resolve(s);
      end
   endtask

   // ---------------- checking ----------------
   task automatic check(input string nm, input int s, input logic [15:0] act, input logic [15:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, s, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         for (int i = 0; i < 3; i++) begin
            check("p_data",     i, o_pdata[i],       m_pdata[i]);
            check("data_valid", i, 16'(o_dv[i]),     16'(m_dv[i]));
            check("par_err",    i, 16'(o_pe[i]),     16'(m_pe[i]));
            check("stp_err",    i, 16'(o_se[i]),     16'(m_se[i]));
            check("busy",       i, 16'(o_busy[i]),   16'(m_busy[i]));
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic step(input int s, input bit st, input bit bv, input bit b, input bit ab);
      sel = s; start_det = st; bit_valid = bv; sampled_bit = b; frame_abort = ab;
      @(posedge clk); #1;
      start_det = 0; bit_valid = 0; frame_abort = 0;
      model_step(s, st, bv, b, ab);
   endtask

   task automatic send_bits(input int s, input logic [31:0] bits, input int n);
      for (int k = 0; k < n; k++) begin
         step(s, 0, 1, bits[k], 0);
         if (k == 2) step(s, 0, 0, 0, 0);   // idle gap mid-frame
      end
   endtask

   task automatic frame(input int s, input bit pen, input bit ptyp, input logic [31:0] bits, input int n);
      par_en = pen; par_typ = ptyp;
      step(s, 1, 0, 0, 0);
      send_bits(s, bits, n);
   endtask

   initial begin
      rst = 1'b1; sel = 0;
      start_det = 0; bit_valid = 0; sampled_bit = 0; frame_abort = 0;
      par_en = 0; par_typ = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk_en = 1'b1;
      step(0, 0, 0, 0, 0);
      step(0, 0, 1, 1, 0);                 // bit_valid in IDLE ignored

      // Basic 8N1 frame 0xA5
      frame(0, 0, 0, 32'h1A5, 9);
      #1;
      check("lit_basic_pdata", 0, o_pdata[0], 16'h00A5);
      check("lit_basic_dv",    0, 16'(o_dv[0]), 16'h1);
      step(0, 0, 0, 0, 0);

      // Even parity good, then bad parity bit
      frame(0, 1, 0, 32'h2A5, 10);
      step(0, 0, 0, 0, 0);
      frame(0, 1, 0, 32'h3A5, 10);
      #1;
      check("lit_par_err", 0, 16'(o_pe[0]), 16'h1);
      check("lit_par_hold", 0, o_pdata[0], 16'h00A5);
      step(0, 0, 0, 0, 0);

      // Odd parity, 2 stops: good frame, then second stop 0
      frame(1, 1, 1, 32'h73C, 11);
      step(1, 0, 0, 0, 0);
      frame(1, 1, 1, 32'h33C, 11);
      #1;
      check("lit_stp_err", 1, 16'(o_se[1]), 16'h1);
      check("lit_stp_nodv", 1, 16'(o_dv[1]), 16'h0);
      step(1, 0, 0, 0, 0);

      // 5-bit MSB-first: bits 1,1,0,0,1 then stop
      frame(2, 0, 0, 32'h33, 6);
      #1;
      check("lit_msb_pdata", 2, o_pdata[2], 16'h0019);
      step(2, 0, 0, 0, 0);

      // Abort after 4th data bit, then clean 0x5A frame
      par_en = 0;
      step(0, 1, 0, 0, 0);
      for (int k = 0; k < 4; k++) step(0, 0, 1, k[0] ^ 1'b0 ? 1'b1 : 1'b0, 0);
      step(0, 0, 0, 0, 1);
      check("lit_abort_busy", 0, 16'(o_busy[0]), 16'h0);
      step(0, 0, 0, 0, 0);
      frame(0, 0, 0, 32'h15A, 9);
      step(0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 1);                 // abort beats start in IDLE
      step(0, 0, 0, 0, 0);

      // start_det with bit_valid in IDLE, then 0xC3; stray start mid-DATA;
      // config change mid-frame has no effect
      par_en = 0;
      step(0, 1, 1, 1, 0);
      for (int k = 0; k < 9; k++) begin
         if (k == 3) begin
            par_en = 1;
            step(0, 1, 0, 0, 0);
         end
         step(0, 0, 1, (32'h1C3 >> k) & 32'h1 ? 1'b1 : 1'b0, 0);
      end
      step(0, 0, 0, 0, 0);

      // Reset asserted while in PARITY
      frame(0, 1, 0, 32'h0A5, 8);
      #1 rst = 1'b1;
      #1;
      check("rst_async_busy",  0, 16'(o_busy[0]), 16'h0);
      check("rst_async_pdata", 0, o_pdata[0], 16'h0000);
      check("rst_async_dv",    0, 16'(o_dv[0]), 16'h0);
      model_reset();
      #3 rst = 1'b0;
      step(0, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0);                 // stale parity strobe lands in IDLE
      frame(2, 0, 0, 32'h2A, 6);           // bits 0,1,0,1,0 stop 1 -> 01010
      step(2, 0, 0, 0, 0);
      step(2, 0, 0, 0, 0);

      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/rx_frame_deserializer.md
Name: rx_frame_deserializer

Overview:
- Parametrised UART RX deserializer.
- Assembles one complete frame from the sampled-bit strobes delivered by the RX edge/data sampler: DATA_WIDTH data bits, an optional parity bit, and STOP_BITS stop bits.
- Keeps its own bit counter, parity accumulator and stop checker; P_DATA updates only on an error-free frame.
- Sits between the RX data sampler and the RX-to-system synchroniser, replacing the fixed 8-bit deserializer plus separate parity/stop checkers.

Parameters:
- DATA_WIDTH, 8, data bits per frame; legal 5..16.
- LSB_FIRST, 1, 1 = first data bit lands in P_DATA[0]; 0 = first data bit lands in P_DATA[DATA_WIDTH-1].
- STOP_BITS, 1, stop bits checked per frame; legal 1 or 2.

Ports:
- CLK, input, 1, RX oversampling-domain clock.
- RST, input, 1, asynchronous, active-high reset.
- start_det, input, 1, one-cycle pulse: a valid start bit has been confirmed, so a frame begins.
- bit_valid, input, 1, one-cycle strobe: sampled_bit holds the next bit of the frame.
- sampled_bit, input, 1, majority-voted bit value.
- frame_abort, input, 1, discard the current frame and return to IDLE.
- PAR_EN, input, 1, parity bit present.
- PAR_TYP, input, 1, 0 = even parity, 1 = odd parity.
- P_DATA, output, DATA_WIDTH, last good frame payload.
- data_valid, output, 1, one-cycle pulse when P_DATA has been updated.
- par_err, output, 1, one-cycle pulse on parity mismatch.
- stp_err, output, 1, one-cycle pulse when a stop bit is sampled 0.
- busy, output, 1, high in every state other than IDLE.

Behaviour:
- Reset (asynchronous, RST=1):
  - State goes to IDLE.
  - P_DATA, the internal shift register, bit counter, parity accumulator and latched config all go to 0.
  - data_valid, par_err, stp_err and busy go to 0.
  - Reset mid-frame discards the frame and produces no pulses.
- All outputs are registered.
- FSM states: IDLE, DATA, PARITY, STOP.
- IDLE:
  - bit_valid is ignored.
  - On start_det: latch PAR_EN and PAR_TYP, clear the counter and accumulator, go to DATA.
  - start_det together with bit_valid in the same cycle: start_det wins and the bit is discarded.
- DATA:
  - On each bit_valid, write sampled_bit into the shadow register at index cnt (LSB_FIRST=1) or DATA_WIDTH-1-cnt (LSB_FIRST=0).
  - Also XOR the bit into the accumulator and increment cnt.
  - After the DATA_WIDTH-th bit, go to PARITY if the latched PAR_EN=1, else STOP.
- PARITY:
  - Expected bit = accumulator XOR latched PAR_TYP.
  - On bit_valid, record a mismatch flag and go to STOP.
- STOP:
  - Each bit_valid checks sampled_bit==1; any 0 sets the stop-error flag.
  - After STOP_BITS strobes, go to IDLE and resolve the frame on that same edge:
    - no error: P_DATA <= shadow register; data_valid=1.
    - parity error: par_err=1; P_DATA is held.
    - stop error: stp_err=1; P_DATA is held.
    - both errors: both flags pulse.
- Pulse timing: every result pulse is high for exactly the one cycle after the edge that samples the final stop strobe. data_valid never coincides with par_err or stp_err.
- Latency: final stop strobe to data_valid is 1 cycle.
- start_det outside IDLE is ignored; the frame in progress continues.
- frame_abort (any state, highest priority after RST):
  - Next state is IDLE.
  - Flags and counter clear; no result pulse; P_DATA is held.
  - If frame_abort and start_det arrive in the same IDLE cycle, frame_abort wins.
- Counter width is clog2(DATA_WIDTH+1). It never wraps: once it reaches DATA_WIDTH the state leaves DATA on the same edge.
- Cycles without bit_valid hold all state; there is no timeout.
- PAR_EN/PAR_TYP changes mid-frame have no effect until the next start_det.

Test Plan:
- Basic frame: DATA_WIDTH=8, LSB_FIRST=1, PAR_EN=0; start_det, then bits 1,0,1,0,0,1,0,1, then stop bit 1 → P_DATA=0xA5, data_valid high for 1 cycle, busy low afterwards, no error flags.
- Even parity: PAR_EN=1, PAR_TYP=0, data 0xA5, parity bit 0 → data_valid. Repeat with parity bit 1 → par_err pulse, P_DATA stays 0xA5 from the prior frame.
- Odd parity with 2 stop bits: STOP_BITS=2, PAR_TYP=1, data 0x3C, parity bit 1, stops 1,0 → stp_err pulse only, no data_valid.
- MSB-first width: DATA_WIDTH=5, LSB_FIRST=0; bits 1,1,0,0,1 with a good stop → P_DATA=5'b11001.
- Abort and reset: frame_abort after the 4th data bit → busy=0 next cycle, no pulses; a following clean 0x5A frame decodes correctly. RST asserted mid-PARITY → all outputs 0 asynchronously.
- Simultaneous events: start_det together with bit_valid in IDLE → bit dropped, frame starts. start_det during DATA → ignored, frame completes with the correct value.
